// File: rtl/fitbit_disp_pkg.sv
// Shared types and constants for the statistics-to-seven-segment formatting path.
package fitbit_disp_pkg;

  localparam int unsigned BCD_W    = 16;
  localparam int unsigned SAT_4DIG = 9999;
  localparam int unsigned SAT_DIST = 999;

  typedef enum logic [1:0] {
    MODE_STEPS = 2'd0,
    MODE_DIST  = 2'd1,
    MODE_ACT   = 2'd2,
    MODE_HAT   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } fsm_state_t;

  // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/stat_bcd_formatter_if.sv
// Statistic inputs and formatted display outputs between the stats core and scan driver.
interface stat_bcd_formatter_if;
  import fitbit_disp_pkg::*;

  logic [31:0]      step_count;
  logic [15:0]      distance_covered;
  logic [3:0]       initial_activity_count;
  logic [15:0]      high_activity_time;
  logic [1:0]       output_mode;
  logic [BCD_W-1:0] bcd;
  logic [3:0]       dp;
  logic [3:0]       blank;
  logic             upd;
  logic             busy;

  modport master (
    output step_count, distance_covered, initial_activity_count,
           high_activity_time, output_mode,
    input  bcd, dp, blank, upd, busy
  );

  modport slave (
    input  step_count, distance_covered, initial_activity_count,
           high_activity_time, output_mode,
    output bcd, dp, blank, upd, busy
  );
endinterface

// File: rtl/stat_bcd_formatter_bin2bcd_serial.sv
// Serial double-dabble converter: one iteration per clock, BIN_W iterations per operand.
module bin2bcd_serial
  import fitbit_disp_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             idle,
  output logic             done,
  output logic [BCD_W-1:0] result
);

  localparam int unsigned ITER_W = $clog2(BIN_W);

  fsm_state_t        state;
  logic [ITER_W-1:0] iter;
  logic [BIN_W-1:0]  bin;
  logic [BCD_W-1:0]  bcd_acc;
  logic [BCD_W-1:0]  adj;

  assign adj    = dabble_adjust(bcd_acc);
  assign idle   = (state == ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = bcd_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      iter    <= '0;
      bin     <= '0;
      bcd_acc <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bin     <= operand;
            bcd_acc <= '0;
            iter    <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_acc <= {adj[BCD_W-2:0], bin[BIN_W-1]};
          bin     <= {bin[BIN_W-2:0], 1'b0};
          iter    <= iter + ITER_W'(1);
          if (iter == ITER_W'(BIN_W - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stat_bcd_formatter.sv
// Selects a statistic, saturates it to four digits, converts to BCD and registers
// digits plus decimal-point and leading-zero blank masks for the scan driver.
module stat_bcd_formatter #(
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned BIN_W          = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  stat_bcd_formatter_if.slave  bus
);
  import fitbit_disp_pkg::*;

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);

  logic [CNT_W-1:0] refresh_cnt;
  logic             refresh_hit;
  mode_t            mode_in;
  mode_t            mode_q;
  logic             pending;
  logic             req;
  logic             start;
  logic [BIN_W-1:0] operand_sat;
  logic             eng_idle;
  logic             eng_done;
  logic [BCD_W-1:0] eng_result;
  logic [3:0]       blank_next;
  logic [3:0]       dp_next;

  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       dp_q;
  logic [3:0]       blank_q;
  logic             upd_q;
  logic             busy_q;

  assign mode_in     = mode_t'(bus.output_mode);
  assign refresh_hit = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));
  assign req         = refresh_hit || (mode_in != mode_q) || pending;
  assign start       = req && eng_idle;

  always_comb begin
    operand_sat = '0;
    unique case (mode_in)
      MODE_STEPS: operand_sat = (bus.step_count > 32'(SAT_4DIG))
                                ? BIN_W'(SAT_4DIG) : bus.step_count[BIN_W-1:0];
      MODE_DIST:  operand_sat = (bus.distance_covered > 16'(SAT_DIST))
                                ? BIN_W'(SAT_DIST) : bus.distance_covered[BIN_W-1:0];
      MODE_ACT:   operand_sat = {{(BIN_W-4){1'b0}}, bus.initial_activity_count};
      MODE_HAT:   operand_sat = (bus.high_activity_time > 16'(SAT_4DIG))
                                ? BIN_W'(SAT_4DIG) : bus.high_activity_time[BIN_W-1:0];
      default:    operand_sat = '0;
    endcase
  end

  // Masks follow the mode latched at capture, not the live mode input.
  always_comb begin
    blank_next    = '0;
    blank_next[3] = (eng_result[15:12] == 4'd0);
    blank_next[2] = blank_next[3] && (eng_result[11:8] == 4'd0);
    blank_next[1] = blank_next[2] && (eng_result[7:4] == 4'd0) && (mode_q != MODE_DIST);
    blank_next[0] = 1'b0;
    dp_next       = (mode_q == MODE_DIST) ? 4'b0010 : 4'b0000;
  end

  bin2bcd_serial #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .operand (operand_sat),
    .idle    (eng_idle),
    .done    (eng_done),
    .result  (eng_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      mode_q      <= MODE_STEPS;
      pending     <= 1'b1;
      bcd_q       <= '0;
      dp_q        <= '0;
      blank_q     <= 4'b1110;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      refresh_cnt <= refresh_hit ? '0 : refresh_cnt + CNT_W'(1);
      upd_q       <= 1'b0;
      if (start) begin
        mode_q  <= mode_in;
        pending <= 1'b0;
        busy_q  <= 1'b1;
      end else if (req) begin
        pending <= 1'b1;
      end
      if (eng_done) begin
        bcd_q   <= eng_result;
        dp_q    <= dp_next;
        blank_q <= blank_next;
        upd_q   <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.dp    = dp_q;
  assign bus.blank = blank_q;
  assign bus.upd   = upd_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_stat_bcd_formatter.sv
// Directed bench for stat_bcd_formatter with a 64-cycle refresh period.
module tb_stat_bcd_formatter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int unsigned edge_no = 0;

  stat_bcd_formatter_if bus ();

  stat_bcd_formatter #(
    .REFRESH_CYCLES (64),
    .BIN_W          (14)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge index since the last reset release; edge 1 is the first post-release edge.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_no <= 0;
    else       edge_no <= edge_no + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until_edge(input int unsigned n);
    while (edge_no < n) @(negedge clk);
  endtask

  initial begin
    int k;
    int upd_seen;

    reset = 1'b1;
    bus.step_count             = '0;
    bus.distance_covered       = '0;
    bus.initial_activity_count = '0;
    bus.high_activity_time     = '0;
    bus.output_mode            = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd",   32'(bus.bcd),   32'h0000);
    check("rst_blank", 32'(bus.blank), 32'b1110);
    check("rst_dp",    32'(bus.dp),    32'h0);
    check("rst_upd",   32'(bus.upd),   32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    reset = 1'b0;

    // First conversion is forced by the pending flag; upd at edge 16.
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) check("first_busy", 32'(bus.busy), 32'h1);
      if (bus.upd === 1'b1) begin
        k = i;
        break;
      end
    end
    check("first_upd_edge", 32'(k),         32'd16);
    check("first_bcd",      32'(bus.bcd),   32'h0000);
    check("first_blank",    32'(bus.blank), 32'b1110);
    check("first_dp",       32'(bus.dp),    32'h0);
    bus.step_count = 32'd1234;
    wait_until_edge(17);
    check("upd_one_cycle", 32'(bus.upd),  32'h0);
    check("idle_busy",     32'(bus.busy), 32'h0);

    wait_until_edge(63);
    check("no_conv_before_refresh", 32'(bus.busy), 32'h0);
    wait_until_edge(64);
    check("refresh_busy", 32'(bus.busy), 32'h1);
    wait_until_edge(79);
    check("s1234_upd",   32'(bus.upd),   32'h1);
    check("s1234_bcd",   32'(bus.bcd),   32'h1234);
    check("s1234_blank", 32'(bus.blank), 32'b0000);
    check("s1234_dp",    32'(bus.dp),    32'h0);

    bus.step_count = 32'd70000;
    wait_until_edge(143);
    check("s70000_upd", 32'(bus.upd), 32'h1);
    check("s70000_bcd", 32'(bus.bcd), 32'h9999);

    // Mode change starts a conversion on the very next edge.
    bus.output_mode      = 2'd1;
    bus.distance_covered = 16'd57;
    wait_until_edge(144);
    check("dist_busy", 32'(bus.busy), 32'h1);
    wait_until_edge(159);
    check("dist_upd",   32'(bus.upd),   32'h1);
    check("dist_bcd",   32'(bus.bcd),   32'h0057);
    check("dist_dp",    32'(bus.dp),    32'b0010);
    check("dist_blank", 32'(bus.blank), 32'b1100);

    bus.output_mode        = 2'd3;
    bus.high_activity_time = 16'd45;
    wait_until_edge(163);
    bus.high_activity_time = 16'd300;
    wait_until_edge(175);
    check("hat45_upd",   32'(bus.upd),   32'h1);
    check("hat45_bcd",   32'(bus.bcd),   32'h0045);
    check("hat45_blank", 32'(bus.blank), 32'b1100);
    check("hat45_dp",    32'(bus.dp),    32'h0);
    wait_until_edge(207);
    check("hat300_upd",   32'(bus.upd),   32'h1);
    check("hat300_bcd",   32'(bus.bcd),   32'h0300);
    check("hat300_blank", 32'(bus.blank), 32'b1000);

    // Mode change at 246, then another mode change and the refresh tick at 256 while busy.
    wait_until_edge(245);
    bus.output_mode = 2'd0;
    wait_until_edge(250);
    bus.output_mode            = 2'd2;
    bus.initial_activity_count = 4'd7;
    wait_until_edge(261);
    check("collapse_a_upd",   32'(bus.upd),   32'h1);
    check("collapse_a_bcd",   32'(bus.bcd),   32'h9999);
    check("collapse_a_blank", 32'(bus.blank), 32'b0000);
    wait_until_edge(262);
    check("collapse_b_busy", 32'(bus.busy), 32'h1);
    wait_until_edge(277);
    check("collapse_b_upd",   32'(bus.upd),   32'h1);
    check("collapse_b_bcd",   32'(bus.bcd),   32'h0007);
    check("collapse_b_blank", 32'(bus.blank), 32'b1110);
    upd_seen = 0;
    for (int e = 278; e <= 318; e++) begin
      wait_until_edge(e);
      if (bus.upd === 1'b1 || bus.busy === 1'b1) upd_seen++;
    end
    check("no_extra_conv", 32'(upd_seen), 32'd0);

    // Reset in the middle of a conversion, then the post-release conversion.
    wait_until_edge(336);
    bus.output_mode      = 2'd1;
    bus.distance_covered = 16'd1234;
    wait_until_edge(341);
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_bcd",   32'(bus.bcd),   32'h0000);
    check("mid_rst_blank", 32'(bus.blank), 32'b1110);
    check("mid_rst_dp",    32'(bus.dp),    32'h0);
    check("mid_rst_busy",  32'(bus.busy),  32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_until_edge(15);
    check("post_rst_busy", 32'(bus.busy), 32'h1);
    check("post_rst_noupd", 32'(bus.upd), 32'h0);
    wait_until_edge(16);
    check("post_rst_upd",   32'(bus.upd),   32'h1);
    check("post_rst_bcd",   32'(bus.bcd),   32'h0999);
    check("post_rst_dp",    32'(bus.dp),    32'b0010);
    check("post_rst_blank", 32'(bus.blank), 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stat_bcd_formatter.md
Name: stat_bcd_formatter

Overview:
- Sits between the fitbit statistics core and the seven-segment scan driver.
- Selects one statistic by output_mode, saturates it to four display digits, and converts it to BCD with a serial double-dabble engine.
- Presents registered digits plus decimal-point and leading-zero-blank masks, so the scan driver does no arithmetic.
- Reconverts on a periodic refresh tick and on every mode change.

Parameters:
- REFRESH_CYCLES, 1000000: clk cycles between periodic reconversions (10 ms at 100 MHz); minimum 32.
- BIN_W, 14: width of the saturated binary operand (covers 9999).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- step_count  in  32  total steps, unsigned
- distance_covered  in  16  distance in tenths of a mile, unsigned fixed point with one fractional digit
- initial_activity_count  in  4  count 0..15
- high_activity_time  in  16  seconds, unsigned
- output_mode  in  2  0=steps, 1=distance, 2=activity count, 3=high-activity time
- bcd  out  16  digit3 in [15:12] (most significant) down to digit0 in [3:0]
- dp  out  4  decimal-point enable per digit, bit i = digit i
- blank  out  4  blank enable per digit, bit i = digit i
- upd  out  1  one-cycle pulse when bcd/dp/blank change
- busy  out  1  high while a conversion is in flight

Behaviour:
- Reset values: bcd=0, dp=0, blank=4'b1110, upd=0, busy=0, refresh counter=0, pending=1, FSM=IDLE.
  - Pending=1 forces a conversion immediately after reset release.
- Trigger sources (any one raises a request):
  - refresh counter reaching REFRESH_CYCLES-1; the counter wraps to 0 and is free-running.
  - output_mode differs from mode_q, the mode latched at the last capture.
  - pending flag set.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, request present at edge N:
    - capture mode_q and the saturated operand; clear pending; iter=0; busy=1; go to SHIFT.
  - SHIFT, edges N+1..N+14, one double-dabble iteration per edge:
    - add 3 to each BCD nibble that is >=5;
    - shift {bcd_acc, bin} left by 1.
    - After the 14th iteration, go to DONE.
  - DONE, edge N+15:
    - write bcd, dp, blank; upd=1 for exactly that cycle; busy=0; go to IDLE.
    - A new capture is possible at edge N+16 at the earliest.
- Requests arriving while busy set pending (single-depth). Multiple requests collapse into one, serviced on return to IDLE.
- Operands are sampled only at the capture edge. Input changes mid-conversion are ignored until the next capture.
- Saturation, unsigned compare on the full input width:
  - mode 0: min(step_count, 9999)
  - mode 1: min(distance_covered, 999)
  - mode 2: zero-extended initial_activity_count
  - mode 3: min(high_activity_time, 9999)
- dp = 4'b0010 in mode 1 (display XX.X); 0 otherwise.
- blank:
  - digit i is blanked when it and all higher digits are 0.
  - digit0 is never blanked.
  - in mode 1, digits 1 and 0 are never blanked (0.0 shown).
- Reset asserted mid-conversion: immediate return to reset values; the partial result is discarded.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package fitbit_disp_pkg holds:
  - mode encodings MODE_STEPS=0, MODE_DIST=1, MODE_ACT=2, MODE_HAT=3;
  - saturation limits SAT_4DIG=9999, SAT_DIST=999;
  - BCD_W=16 and the FSM state encoding.
- One sub-module, bin2bcd_serial:
  - start/done handshake, 14-bit operand in, 16-bit BCD out, 14 iterations.
  - The top level keeps the trigger logic, saturation, mode latch and mask generation.

Test Plan (REFRESH_CYCLES=64):
- Release reset with all inputs 0 -> upd pulses 15 cycles after the first post-reset edge; bcd=16'h0000, blank=4'b1110, dp=0.
- mode 0, step_count=1234 -> after next refresh, bcd=16'h1234, blank=0, dp=0.
- mode 0, step_count=70000 -> bcd=16'h9999 (saturated).
- Switch to mode 1 with distance_covered=57 -> conversion starts on the edge the mode change is seen, without waiting for refresh; bcd=16'h0057, dp=4'b0010, blank=4'b1100.
- Change high_activity_time mid-conversion in mode 3 (old 45, new 300):
  - first upd shows 16'h0045, blank=4'b1100;
  - the next conversion shows 16'h0300.
- Mode change plus refresh tick while busy -> exactly one extra conversion follows. Assert reset during SHIFT -> outputs return to reset values at once, and the post-release conversion completes correctly.
